// File: rtl/msgseq_tx.sv
// Message sequencer: streams a MSG_LEN-byte ROM message into a txuart-style byte
// transmitter on trigger and/or period tick. Define MSGSEQ_COUNTER_EN to append a hex message count.
module msgseq_tx #(
  parameter int CLOCK_RATE_HZ = 16_000_000,
  parameter int PERIOD_CLKS   = CLOCK_RATE_HZ,
  parameter int AW            = 5,
  parameter int MSG_LEN       = 16,
  parameter     INIT_FILE     = "hello.hex"
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_enable,
  input  logic       i_trigger,
  input  logic       i_busy,
  output logic       o_stb,
  output logic [7:0] o_data,
  output logic       o_active,
  output logic       o_done
);

  localparam logic [AW-1:0]   LAST_IDX    = AW'(MSG_LEN - 1);
  localparam logic [127:0]    HELLO_IMG   = "Hello, World! \n\r";
  localparam bit              BUILTIN_IMG = (INIT_FILE == "hello.hex");

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SEND,
`ifdef MSGSEQ_COUNTER_EN
    S_HEX,
`endif
    S_DONE
  } state_t;

  state_t        state_q;
  logic [AW-1:0] index_q;
  logic          pending_q;
  logic          stb_q;
  logic [7:0]    data_q;
  logic          active_q;
  logic          done_q;
  logic          tick;
  logic          req;
  logic [7:0]    rom [2**AW];

  // The image is elaborated as constants; an unknown image name leaves the ROM blank.
  generate
    for (genvar gi = 0; gi < 2**AW; gi++) begin : g_rom
      if (BUILTIN_IMG && gi < 16) begin : g_img
        assign rom[gi] = HELLO_IMG[8*(15-gi) +: 8];
      end else begin : g_blank
        assign rom[gi] = 8'h00;
      end
    end
  endgenerate

  generate
    if (PERIOD_CLKS > 0) begin : g_period
      localparam logic [31:0] RELOAD = 32'(PERIOD_CLKS - 1);
      logic [31:0] period_q;
      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
          period_q <= RELOAD;
        end else if (!i_enable) begin
          period_q <= RELOAD;
        end else if (period_q == 32'd0) begin
          period_q <= RELOAD;
        end else begin
          period_q <= period_q - 32'd1;
        end
      end
      assign tick = i_enable && (period_q == 32'd0);
    end else begin : g_no_period
      assign tick = 1'b0;
    end
  endgenerate

  assign req = (i_trigger || tick) && i_enable;

`ifdef MSGSEQ_COUNTER_EN
  logic [15:0] count_q;
  logic        hex_q;
  logic [1:0]  dig_q;
  logic [3:0]  nib;
  logic [7:0]  hex_char;

  // Digit 0 is the most significant nibble.
  assign nib      = count_q[{~dig_q, 2'b00} +: 4];
  assign hex_char = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= S_IDLE;
      index_q   <= '0;
      pending_q <= 1'b0;
      stb_q     <= 1'b0;
      data_q    <= 8'h00;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
`ifdef MSGSEQ_COUNTER_EN
      count_q   <= 16'h0000;
      hex_q     <= 1'b0;
      dig_q     <= 2'd0;
`endif
    end else begin
      done_q    <= 1'b0;
      pending_q <= pending_q | req;
      case (state_q)
        S_IDLE: begin
          if (pending_q || req) begin
            pending_q <= 1'b0;
            index_q   <= '0;
            active_q  <= 1'b1;
            state_q   <= S_FETCH;
`ifdef MSGSEQ_COUNTER_EN
            hex_q     <= 1'b0;
            dig_q     <= 2'd0;
`endif
          end
        end
        S_FETCH: begin
          data_q  <= rom[index_q];
          stb_q   <= 1'b1;
          state_q <= S_SEND;
        end
`ifdef MSGSEQ_COUNTER_EN
        S_HEX: begin
          data_q  <= hex_char;
          stb_q   <= 1'b1;
          state_q <= S_SEND;
        end
`endif
        S_SEND: begin
          if (!i_busy) begin
            stb_q <= 1'b0;
`ifdef MSGSEQ_COUNTER_EN
            if (hex_q) begin
              dig_q <= dig_q + 2'd1;
              if (dig_q == 2'd3) begin
                done_q   <= 1'b1;
                active_q <= 1'b0;
                state_q  <= S_DONE;
              end else begin
                state_q  <= S_HEX;
              end
            end else begin
              index_q <= index_q + 1'b1;
              if (index_q == LAST_IDX) begin
                hex_q   <= 1'b1;
                state_q <= S_HEX;
              end else begin
                state_q <= S_FETCH;
              end
            end
`else
            // Compare the pre-increment index so MSG_LEN == 2**AW needs no extra bit.
            index_q <= index_q + 1'b1;
            if (index_q == LAST_IDX) begin
              done_q   <= 1'b1;
              active_q <= 1'b0;
              state_q  <= S_DONE;
            end else begin
              state_q  <= S_FETCH;
            end
`endif
          end
        end
        S_DONE: begin
`ifdef MSGSEQ_COUNTER_EN
          count_q <= count_q + 16'd1;
`endif
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_stb    = stb_q;
  assign o_data   = data_q;
  assign o_active = active_q;
  assign o_done   = done_q;

endmodule

// File: tb/tb_msgseq_tx.sv
// Directed self-checking bench for msgseq_tx: one task per scenario, inline checks,
// expected bytes from a local copy of the message text plus a bench-side message counter.
module tb_msgseq_tx;

`ifdef MSGSEQ_COUNTER_EN
  localparam int NBYTES = 20;
`else
  localparam int NBYTES = 16;
`endif

  logic       clk = 1'b0;
  logic       rst_n, en, trig, busy, en_p;
  logic       stb, act, done, stb_p, act_p, done_p;
  logic [7:0] data, data_p;

  always #5 clk = ~clk;

  msgseq_tx #(.PERIOD_CLKS(0)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_trigger(trig), .i_busy(busy),
    .o_stb(stb), .o_data(data), .o_active(act), .o_done(done)
  );

  msgseq_tx #(.PERIOD_CLKS(100)) dut_p (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(en_p), .i_trigger(1'b0), .i_busy(1'b0),
    .o_stb(stb_p), .o_data(data_p), .o_active(act_p), .o_done(done_p)
  );

  int         total = 0;
  int         bad = 0;
  int         msg = 0;
  logic [7:0] acc_q[$];
  int         done_cnt = 0, stb_cnt = 0, act_cnt = 0;
  int         pcyc;
  int         starts_p[$];
  int         done_p_cnt = 0;
  logic       act_p_prev = 1'b0;

  logic [7:0] hello [16] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20, 8'h57,
                             8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h20, 8'h0A, 8'h0D};

  always @(posedge clk) begin
    if (!rst_n) pcyc <= 0;
    else        pcyc <= pcyc + 1;
  end

  // Accepts are observed half a cycle before the edge that performs them.
  always @(negedge clk) begin
    if (stb && !busy) acc_q.push_back(data);
    if (done) done_cnt++;
    if (stb) stb_cnt++;
    if (act) act_cnt++;
    if (act_p && !act_p_prev) starts_p.push_back(pcyc);
    if (done_p) done_p_cnt++;
    act_p_prev = act_p;
  end

  function automatic logic [7:0] exp_byte(input int pos, input int msgnum);
    logic [15:0] m;
    logic [3:0]  nib;
    if (pos < 16) return hello[pos];
    m   = msgnum[15:0];
    nib = m[4*(19-pos) +: 4];
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    tick_n(1);
    trig = 1'b0;
  endtask

  task automatic wait_done(input int target, input int limit, output bit ok);
    int i;
    i  = 0;
    ok = (done_cnt >= target);
    while (!ok && i < limit) begin
      tick_n(1);
      i++;
      ok = (done_cnt >= target);
    end
  endtask

  task automatic wait_accepts(input int target, input int limit, output bit ok);
    int i;
    i  = 0;
    ok = (acc_q.size() >= target);
    while (!ok && i < limit) begin
      tick_n(1);
      i++;
      ok = (acc_q.size() >= target);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; trig = 1'b0; busy = 1'b0; en_p = 1'b1;
    tick_n(3);
    total++; if (stb !== 1'b0) begin bad++; $display("FAIL reset_stb: got %b want 0", stb); end
    total++; if (data !== 8'h00) begin bad++; $display("FAIL reset_data: got %02h want 00", data); end
    total++; if (act !== 1'b0) begin bad++; $display("FAIL reset_active: got %b want 0", act); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (stb_p !== 1'b0) begin bad++; $display("FAIL reset_stb_p: got %b want 0", stb_p); end
    rst_n = 1'b1;
    $display("reset: released, stb=%b data=%02h active=%b done=%b", stb, data, act, done);
  endtask

  task automatic test_periodic();
    tick_n(350);
    en_p = 1'b0;
    tick_n(300);
    total++;
    if (starts_p.size() !== 3) begin
      bad++; $display("FAIL periodic_count: got %0d starts want 3", starts_p.size());
    end
    for (int i = 0; i < 3 && i < starts_p.size(); i++) begin
      total++;
      if (starts_p[i] !== 100 * (i + 1)) begin
        bad++; $display("FAIL periodic_start%0d: got clock %0d want %0d", i, starts_p[i], 100 * (i + 1));
      end
      $display("periodic: start %0d at clock %0d", i, starts_p[i]);
    end
    total++;
    if (done_p_cnt !== 3) begin bad++; $display("FAIL periodic_done: got %0d want 3", done_p_cnt); end
  endtask

  task automatic test_single();
    int base, d0, s0, a0;
    bit ok;
    base = acc_q.size(); d0 = done_cnt; s0 = stb_cnt; a0 = act_cnt;
    pulse_trig();
    total++; if (act !== 1'b1) begin bad++; $display("FAIL single_latency_active: got %b want 1", act); end
    total++; if (stb !== 1'b0) begin bad++; $display("FAIL single_fetch_stb: got %b want 0", stb); end
    tick_n(1);
    total++; if (stb !== 1'b1 || data !== 8'h48) begin
      bad++; $display("FAIL single_first_byte: got stb=%b data=%02h want stb=1 data=48", stb, data);
    end
    wait_done(d0 + 1, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_timeout: got no done want done"); end
    tick_n(5);
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL single_done_pulses: got %0d want 1", done_cnt - d0); end
    total++; if (act !== 1'b0) begin bad++; $display("FAIL single_active_after: got %b want 0", act); end
    total++; if (stb_cnt - s0 !== NBYTES) begin bad++; $display("FAIL single_stb_cycles: got %0d want %0d", stb_cnt - s0, NBYTES); end
    total++; if (act_cnt - a0 !== 2 * NBYTES) begin bad++; $display("FAIL single_active_cycles: got %0d want %0d", act_cnt - a0, 2 * NBYTES); end
    total++; if (acc_q.size() - base !== NBYTES) begin bad++; $display("FAIL single_len: got %0d want %0d", acc_q.size() - base, NBYTES); end
    for (int i = 0; i < NBYTES && base + i < acc_q.size(); i++) begin
      total++;
      if (acc_q[base + i] !== exp_byte(i, msg)) begin
        bad++; $display("FAIL single_byte%0d: got %02h want %02h", i, acc_q[base + i], exp_byte(i, msg));
      end
    end
    $display("single: %0d bytes, done pulses %0d", acc_q.size() - base, done_cnt - d0);
    msg++;
  endtask

  task automatic test_enable();
    int base, d0, a0;
    bit ok;
    a0 = act_cnt;
    en = 1'b0;
    pulse_trig();
    tick_n(30);
    en = 1'b1;
    tick_n(5);
    total++; if (act_cnt - a0 !== 0) begin bad++; $display("FAIL enable_blocked: got %0d active cycles want 0", act_cnt - a0); end
    base = acc_q.size(); d0 = done_cnt;
    pulse_trig();
    tick_n(6);
    en = 1'b0;
    wait_done(d0 + 1, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL enable_drop_timeout: got no done want done"); end
    en = 1'b1;
    total++; if (acc_q.size() - base !== NBYTES) begin bad++; $display("FAIL enable_drop_len: got %0d want %0d", acc_q.size() - base, NBYTES); end
    for (int i = 0; i < NBYTES && base + i < acc_q.size(); i++) begin
      total++;
      if (acc_q[base + i] !== exp_byte(i, msg)) begin
        bad++; $display("FAIL enable_drop_byte%0d: got %02h want %02h", i, acc_q[base + i], exp_byte(i, msg));
      end
    end
    $display("enable: blocked start ok, mid-message drop sent %0d bytes", acc_q.size() - base);
    msg++;
  endtask

  task automatic test_back_to_back();
    int base, d0;
    bit ok;
    base = acc_q.size(); d0 = done_cnt;
    pulse_trig();
    tick_n(4); pulse_trig();
    tick_n(3); pulse_trig();
    tick_n(3); pulse_trig();
    wait_done(d0 + 1, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_first_timeout: got no done want done"); end
    total++; if (act !== 1'b0) begin bad++; $display("FAIL b2b_idle_gap: got active=%b want 0", act); end
    tick_n(1);
    total++; if (act !== 1'b1) begin bad++; $display("FAIL b2b_restart: got active=%b want 1", act); end
    wait_done(d0 + 2, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_second_timeout: got no done want done"); end
    tick_n(100);
    total++; if (done_cnt - d0 !== 2) begin bad++; $display("FAIL b2b_msg_count: got %0d want 2", done_cnt - d0); end
    total++; if (acc_q.size() - base !== 2 * NBYTES) begin bad++; $display("FAIL b2b_len: got %0d want %0d", acc_q.size() - base, 2 * NBYTES); end
    for (int i = 0; i < 2 * NBYTES && base + i < acc_q.size(); i++) begin
      total++;
      if (acc_q[base + i] !== exp_byte(i % NBYTES, msg + i / NBYTES)) begin
        bad++; $display("FAIL b2b_byte%0d: got %02h want %02h", i, acc_q[base + i], exp_byte(i % NBYTES, msg + i / NBYTES));
      end
    end
    $display("back_to_back: %0d messages, %0d bytes", done_cnt - d0, acc_q.size() - base);
    msg += 2;
  endtask

  task automatic test_busy();
    int base, d0, held_bad;
    bit ok;
    base = acc_q.size(); d0 = done_cnt; held_bad = 0;
    pulse_trig();
    wait_accepts(base + 3, 100, ok);
    total++; if (!ok) begin bad++; $display("FAIL busy_reach_byte3: got %0d accepts want 3", acc_q.size() - base); end
    busy = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick_n(1);
      if (stb !== 1'b1 || data !== 8'h6C) held_bad++;
    end
    total++; if (held_bad !== 0) begin bad++; $display("FAIL busy_hold: got %0d bad cycles want 0 (stb=%b data=%02h)", held_bad, stb, data); end
    total++; if (acc_q.size() - base !== 3) begin bad++; $display("FAIL busy_no_advance: got %0d accepts want 3", acc_q.size() - base); end
    busy = 1'b0;
    wait_done(d0 + 1, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL busy_timeout: got no done want done"); end
    total++; if (acc_q.size() - base !== NBYTES) begin bad++; $display("FAIL busy_len: got %0d want %0d", acc_q.size() - base, NBYTES); end
    for (int i = 0; i < NBYTES && base + i < acc_q.size(); i++) begin
      total++;
      if (acc_q[base + i] !== exp_byte(i, msg)) begin
        bad++; $display("FAIL busy_byte%0d: got %02h want %02h", i, acc_q[base + i], exp_byte(i, msg));
      end
    end
    $display("busy: stalled 50 clocks on byte 3, message %0d bytes", acc_q.size() - base);
    msg++;
  endtask

  task automatic test_reset_mid();
    int base, s0, d0;
    bit ok;
    base = acc_q.size();
    pulse_trig();
    wait_accepts(base + 7, 100, ok);
    total++; if (!ok) begin bad++; $display("FAIL rmid_reach_byte7: got %0d accepts want 7", acc_q.size() - base); end
    busy = 1'b1;
    tick_n(1);
    total++; if (stb !== 1'b1 || data !== exp_byte(7, 0)) begin
      bad++; $display("FAIL rmid_pending: got stb=%b data=%02h want stb=1 data=%02h", stb, data, exp_byte(7, 0));
    end
    #2 rst_n = 1'b0;
    #1;
    total++; if (stb !== 1'b0) begin bad++; $display("FAIL rmid_async_stb: got %b want 0", stb); end
    total++; if (act !== 1'b0) begin bad++; $display("FAIL rmid_async_active: got %b want 0", act); end
    tick_n(2);
    rst_n = 1'b1;
    busy  = 1'b0;
    msg   = 0;
    s0 = stb_cnt; base = acc_q.size(); d0 = done_cnt;
    tick_n(30);
    total++; if (stb_cnt - s0 !== 0) begin bad++; $display("FAIL rmid_silent: got %0d stb cycles want 0", stb_cnt - s0); end
    pulse_trig();
    wait_done(d0 + 1, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL rmid_timeout: got no done want done"); end
    total++; if (acc_q.size() - base !== NBYTES) begin bad++; $display("FAIL rmid_len: got %0d want %0d", acc_q.size() - base, NBYTES); end
    for (int i = 0; i < NBYTES && base + i < acc_q.size(); i++) begin
      total++;
      if (acc_q[base + i] !== exp_byte(i, msg)) begin
        bad++; $display("FAIL rmid_byte%0d: got %02h want %02h", i, acc_q[base + i], exp_byte(i, msg));
      end
    end
    $display("reset_mid: restart sent %0d bytes from byte 0", acc_q.size() - base);
    msg++;
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_single();
    test_enable();
    test_back_to_back();
    test_busy();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
